// File: rtl/vend_credit_ctrl_if.sv
// Board-side bundle of the vend credit controller: c_e enable, raw switches,
// price input and the registered credit/dispense/change outputs.
interface vend_credit_ctrl_if #(
    parameter int unsigned W = 8
);
    logic         c_e;
    logic         coin_n;
    logic         coin_d;
    logic         coin_q;
    logic         btn_buy;
    logic         btn_refund;
    logic [W-1:0] price;
    logic [W-1:0] credit;
    logic         dispense;
    logic         change_valid;
    logic [W-1:0] change_amt;
    logic         coin_reject;
    logic         short;
    logic         busy;

    // Board / stimulus side
    modport master (
        output c_e, coin_n, coin_d, coin_q, btn_buy, btn_refund, price,
        input  credit, dispense, change_valid, change_amt, coin_reject, short, busy
    );

    // Controller side
    modport slave (
        input  c_e, coin_n, coin_d, coin_q, btn_buy, btn_refund, price,
        output credit, dispense, change_valid, change_amt, coin_reject, short, busy
    );
endinterface

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: debounces coins and buttons on c_e rising edges,
// accumulates credit and runs the IDLE/VEND/CHANGE transaction machine.
module vend_credit_ctrl #(
    parameter int unsigned DB_TICKS   = 3,
    parameter int unsigned W          = 8,
    parameter int unsigned CREDIT_MAX = 250,
    parameter int unsigned VAL_N      = 5,
    parameter int unsigned VAL_D      = 10,
    parameter int unsigned VAL_Q      = 25
) (
    input logic               clk,
    input logic               clr_n,
    vend_credit_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    localparam int unsigned NCH     = 5;
    localparam logic [3:0]  DB_LAST = 4'(DB_TICKS - 1);
    localparam logic [W:0]  MAX_X   = (W+1)'(CREDIT_MAX);
    localparam logic [W:0]  V_N     = (W+1)'(VAL_N);
    localparam logic [W:0]  V_D     = (W+1)'(VAL_D);
    localparam logic [W:0]  V_Q     = (W+1)'(VAL_Q);

    // Channel order: 0 nickel, 1 dime, 2 quarter, 3 buy, 4 refund
    logic [NCH-1:0] raw, db, db_d, ev;
    logic [3:0]     cnt [NCH];
    logic           c_e_d, tick;

    state_t         state, state_nx;
    logic [W-1:0]   price_l, price_l_nx, credit_nx, amt_nx, remain;
    logic [W:0]     coin_val, coin_sum;
    logic           disp_nx, cv_nx, rej_nx, short_nx;
    logic           coin_ev, buy_ev, ref_ev;

    assign raw     = {bus.btn_refund, bus.btn_buy, bus.coin_q, bus.coin_d, bus.coin_n};
    assign tick    = bus.c_e & ~c_e_d;
    assign ev      = db & ~db_d;
    assign coin_ev = |ev[2:0];
    assign buy_ev  = ev[3];
    assign ref_ev  = ev[4];

    // Edge-detect c_e and debounce all five inputs on each tick
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            c_e_d <= 1'b0;
            db    <= '0;
            db_d  <= '0;
            for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            c_e_d <= bus.c_e;
            db_d  <= db;
            if (tick) begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (raw[i] == db[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == DB_LAST) begin
                        db[i]  <= raw[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    // Next state and next registered outputs; change pulses are decided one
    // cycle early so change_valid is already registered during CHANGE.
    always_comb begin
        coin_val   = ev[2] ? V_Q : (ev[1] ? V_D : V_N);
        coin_sum   = {1'b0, bus.credit} + coin_val;
        remain     = bus.credit - price_l;
        state_nx   = state;
        price_l_nx = price_l;
        credit_nx  = bus.credit;
        amt_nx     = bus.change_amt;
        disp_nx    = 1'b0;
        cv_nx      = 1'b0;
        rej_nx     = 1'b0;
        short_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ref_ev) begin
                    if (bus.credit != '0) begin
                        state_nx = CHANGE;
                        cv_nx    = 1'b1;
                        amt_nx   = bus.credit;
                    end
                end else if (buy_ev) begin
                    if (bus.price != '0 && bus.credit >= bus.price) begin
                        price_l_nx = bus.price;
                        state_nx   = VEND;
                        disp_nx    = 1'b1;
                    end else begin
                        short_nx = 1'b1;
                    end
                end
                if (coin_ev) begin
                    if (buy_ev || ref_ev || coin_sum > MAX_X) rej_nx = 1'b1;
                    else credit_nx = coin_sum[W-1:0];
                end
            end
            VEND: begin
                credit_nx = remain;
                state_nx  = CHANGE;
                if (remain != '0) begin
                    cv_nx  = 1'b1;
                    amt_nx = remain;
                end
                rej_nx = coin_ev;
            end
            CHANGE: begin
                credit_nx = '0;
                state_nx  = IDLE;
                rej_nx    = coin_ev;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state and latched price
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            price_l <= '0;
        end else begin
            state   <= state_nx;
            price_l <= price_l_nx;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bus.credit       <= '0;
            bus.change_amt   <= '0;
            bus.dispense     <= 1'b0;
            bus.change_valid <= 1'b0;
            bus.coin_reject  <= 1'b0;
            bus.short        <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.credit       <= credit_nx;
            bus.change_amt   <= amt_nx;
            bus.dispense     <= disp_nx;
            bus.change_valid <= cv_nx;
            bus.coin_reject  <= rej_nx;
            bus.short        <= short_nx;
            bus.busy         <= (state_nx != IDLE);
        end
    end
endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: transaction-level credit model,
// directed scenarios from the feature list plus a randomized operation mix.
module tb_vend_credit_ctrl;
    localparam int unsigned W  = 8;
    localparam int unsigned DB = 3;
    localparam int unsigned CM = 250;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Pulse monitor state (written only by the monitor)
    int   cyc = 0;
    int   n_disp = 0, n_chg = 0, n_rej = 0, n_short = 0, n_busy = 0;
    int   disp_cyc = 0, chg_cyc = 0;

    // Reference model state
    int   m_credit = 0;
    int   m_amt = 0;

    vend_credit_ctrl_if #(.W(W)) bus ();

    vend_credit_ctrl #(
        .DB_TICKS(DB), .W(W), .CREDIT_MAX(CM), .VAL_N(5), .VAL_D(10), .VAL_Q(25)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Count output pulses mid-cycle
    always @(negedge clk) begin
        if (clr_n) begin
            if (bus.dispense)     begin n_disp  <= n_disp + 1; disp_cyc <= cyc; end
            if (bus.change_valid) begin n_chg   <= n_chg + 1;  chg_cyc  <= cyc; end
            if (bus.coin_reject)  n_rej   <= n_rej + 1;
            if (bus.short)        n_short <= n_short + 1;
            if (bus.busy)         n_busy  <= n_busy + 1;
        end
    end

    // One c_e period: 4 clocks high, 4 clocks low (one tick per call)
    task automatic step_tick();
        bus.c_e = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        bus.c_e = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    // mask bits: 0 nickel, 1 dime, 2 quarter, 3 buy, 4 refund
    task automatic op(input logic [4:0] mask, input int pr, input int unsigned hold);
        int s_disp, s_chg, s_rej, s_short;
        int e_disp, e_chg, e_rej, e_short, v;
        s_disp = n_disp; s_chg = n_chg; s_rej = n_rej; s_short = n_short;
        e_disp = 0; e_chg = 0; e_rej = 0; e_short = 0;

        bus.price = W'(pr);
        {bus.btn_refund, bus.btn_buy, bus.coin_q, bus.coin_d, bus.coin_n} = mask;
        repeat (hold) step_tick();
        {bus.btn_refund, bus.btn_buy, bus.coin_q, bus.coin_d, bus.coin_n} = '0;
        repeat (DB + 1) step_tick();

        if (hold >= DB) begin
            if (mask[4]) begin
                if (m_credit > 0) begin e_chg = 1; m_amt = m_credit; m_credit = 0; end
            end else if (mask[3]) begin
                if (pr != 0 && m_credit >= pr) begin
                    e_disp = 1;
                    if (m_credit > pr) begin e_chg = 1; m_amt = m_credit - pr; end
                    m_credit = 0;
                end else begin
                    e_short = 1;
                end
            end
            if (mask[2:0] != 3'b000) begin
                if (mask[4] || mask[3]) e_rej = 1;
                else begin
                    v = mask[2] ? 25 : (mask[1] ? 10 : 5);
                    if (m_credit + v <= CM) m_credit = m_credit + v;
                    else e_rej = 1;
                end
            end
        end

        n_checks++;
        if (bus.credit !== W'(m_credit)) begin
            n_fail++; $display("FAIL credit mask=%b price=%0d: got %0d want %0d", mask, pr, bus.credit, m_credit);
        end
        n_checks++;
        if (n_disp - s_disp !== e_disp) begin
            n_fail++; $display("FAIL dispense_count mask=%b price=%0d: got %0d want %0d", mask, pr, n_disp - s_disp, e_disp);
        end
        n_checks++;
        if (n_chg - s_chg !== e_chg) begin
            n_fail++; $display("FAIL change_count mask=%b price=%0d: got %0d want %0d", mask, pr, n_chg - s_chg, e_chg);
        end
        n_checks++;
        if (bus.change_amt !== W'(m_amt)) begin
            n_fail++; $display("FAIL change_amt mask=%b price=%0d: got %0d want %0d", mask, pr, bus.change_amt, m_amt);
        end
        n_checks++;
        if (n_rej - s_rej !== e_rej) begin
            n_fail++; $display("FAIL reject_count mask=%b: got %0d want %0d", mask, n_rej - s_rej, e_rej);
        end
        n_checks++;
        if (n_short - s_short !== e_short) begin
            n_fail++; $display("FAIL short_count mask=%b price=%0d: got %0d want %0d", mask, pr, n_short - s_short, e_short);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_idle: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.credit, bus.change_amt, bus.dispense, bus.change_valid,
             bus.coin_reject, bus.short, bus.busy} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: credit=%0d amt=%0d disp=%b cv=%b rej=%b short=%b busy=%b want all 0",
                bus.credit, bus.change_amt, bus.dispense, bus.change_valid, bus.coin_reject, bus.short, bus.busy);
        end
    endtask

    task automatic test_glitch();
        op(5'b00100, 0, 1);         // single-tick glitch
        op(5'b00100, 0, DB - 1);    // one tick short of the threshold
        op(5'b00100, 0, 10);        // held long: one increment only
    endtask

    task automatic test_accumulate();
        op(5'b10000, 0, DB + 1);    // refund whatever is there
        repeat (10) op(5'b00100, 0, DB + 1);
        op(5'b00100, 0, DB + 1);    // 11th quarter rejected
        op(5'b00001, 0, DB + 1);    // nickel at 250 rejected
        op(5'b10000, 0, DB + 1);
    endtask

    task automatic test_vend_change();
        int s_busy;
        repeat (4) op(5'b00100, 0, DB + 1);
        s_busy = n_busy;
        op(5'b01000, 75, DB + 1);
        n_checks++;
        if (n_busy - s_busy !== 2) begin
            n_fail++; $display("FAIL busy_cycles: got %0d want 2", n_busy - s_busy);
        end
        n_checks++;
        if (chg_cyc - disp_cyc !== 1) begin
            n_fail++; $display("FAIL change_latency: got %0d want 1 cycle after dispense", chg_cyc - disp_cyc);
        end
    endtask

    task automatic test_exact_short();
        repeat (2) op(5'b00100, 0, DB + 1);
        op(5'b01000, 50, DB + 1);   // exact pay, no change
        op(5'b00100, 0, DB + 1);
        op(5'b00001, 0, DB + 1);    // credit 30
        op(5'b01000, 50, DB + 1);   // short
        op(5'b01000, 0, DB + 1);    // zero price is short
    endtask

    task automatic test_collisions();
        op(5'b00010, 0, DB + 1);    // credit 40
        op(5'b11000, 10, DB + 1);   // buy+refund: refund wins
        op(5'b01010, 5, DB + 1);    // coin with buy at credit 0
        op(5'b00101, 0, DB + 1);    // Q+N counts 25 only
        op(5'b10001, 0, DB + 1);    // coin with refund
    endtask

    task automatic test_random();
        logic [4:0] mask;
        int unsigned hold;
        for (int k = 0; k < 40; k++) begin
            mask = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 2) != 0) mask[4:3] = 2'b00;
            hold = ($urandom_range(0, 5) == 0) ? 1 : DB + $urandom_range(0, 2);
            op(mask, int'($urandom_range(0, 120)), hold);
        end
    endtask

    task automatic test_reset_mid();
        int  s_chg;
        bit  seen;
        op(5'b10000, 0, DB + 1);
        repeat (2) op(5'b00100, 0, DB + 1);
        s_chg = n_chg;
        seen  = 0;
        bus.price   = 8'd20;
        bus.btn_buy = 1'b1;
        for (int i = 0; i < 80 && !seen; i++) begin
            bus.c_e = ((i % 8) < 4);
            @(posedge clk); #1;
            if (bus.dispense === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL reset_mid_vend_seen: got no dispense want dispense within 80 cycles");
        end
        clr_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.credit, bus.change_amt, bus.dispense, bus.change_valid,
             bus.coin_reject, bus.short, bus.busy} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: credit=%0d amt=%0d disp=%b cv=%b busy=%b want all 0",
                bus.credit, bus.change_amt, bus.dispense, bus.change_valid, bus.busy);
        end
        bus.btn_buy = 1'b0;
        bus.c_e     = 1'b0;
        repeat (3) @(posedge clk);
        #1 clr_n = 1'b1;
        repeat (16) begin @(posedge clk); #1; end
        n_checks++;
        if (n_chg - s_chg !== 0) begin
            n_fail++; $display("FAIL reset_no_change: got %0d change pulses want 0", n_chg - s_chg);
        end
        m_credit = 0;
        m_amt    = 0;
        op(5'b00010, 0, DB + 1);    // dime after reset -> 10
    endtask

    initial begin
        bus.c_e = 1'b0; bus.coin_n = 1'b0; bus.coin_d = 1'b0; bus.coin_q = 1'b0;
        bus.btn_buy = 1'b0; bus.btn_refund = 1'b0; bus.price = '0;
        #12;
        test_reset();
        clr_n = 1'b1;
        @(posedge clk); #1;
        test_glitch();
        test_accumulate();
        test_vend_change();
        test_exact_short();
        test_collisions();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
- Downstream consumer of the slow enable square wave `c_e` from the clock-enable divider.
- Debounces the three coin inputs and the buy/refund buttons, sampling them on each rising edge of `c_e`.
- Accumulates customer credit and runs the vend/change/refund state machine that drives the dispenser and change outputs.
- Sits between the raw board buttons and the display/dispense logic.

Parameters:
- DB_TICKS, default 3: number of consecutive `c_e` ticks a raw input must differ from its debounced state before the debounced state flips. Legal range 1..15.
- W, default 8: width of the price, credit and change datapath.
- CREDIT_MAX, default 250: maximum credit that may be held; must be ≤ 2^W−1.
- VAL_N, default 5: value of a nickel.
- VAL_D, default 10: value of a dime.
- VAL_Q, default 25: value of a quarter.

Ports:
- clk  in  1  system clock, 100 MHz.
- clr_n  in  1  asynchronous active-low reset.
- c_e  in  1  slow enable square wave from the divider; synchronous to clk.
- coin_n  in  1  raw nickel switch, active-high, bouncy.
- coin_d  in  1  raw dime switch, active-high, bouncy.
- coin_q  in  1  raw quarter switch, active-high, bouncy.
- btn_buy  in  1  raw buy button, active-high, bouncy.
- btn_refund  in  1  raw refund button, active-high, bouncy.
- price  in  W  price of the selected item; sampled on a buy event.
- credit  out  W  current credit.
- dispense  out  1  one-clk pulse that releases an item.
- change_valid  out  1  one-clk pulse; `change_amt` is valid during this cycle.
- change_amt  out  W  amount to return; holds its value until the next change.
- coin_reject  out  1  one-clk pulse when an inserted coin is refused.
- short  out  1  one-clk pulse when buy is refused because credit < price or price = 0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (clr_n = 0, asynchronous):
  - All outputs are 0.
  - All debounce counters are 0 and all debounced states are 0.
  - The `c_e` history register is 0; the FSM is in IDLE.
  - Reset may assert in any state, including mid-vend; no dispense or change pulse may follow it.
- Tick generation: `tick` = `c_e` & ~`c_e_d`, where `c_e_d` is `c_e` registered once. This gives one clk-wide pulse per `c_e` rising edge. Falling edges are ignored.
- Debounce (five identical channels, updated only on clock cycles where `tick` = 1):
  - If raw = debounced, the counter clears.
  - Otherwise the counter increments. When it reaches DB_TICKS−1 on a tick, the debounced state takes the raw value and the counter clears.
  - A single-tick glitch therefore never propagates when DB_TICKS ≥ 2.
- Event: a debounced 0→1 transition produces a one-clk internal event pulse in the cycle after the debounced state flips. Release (1→0) produces no event.
- FSM, IDLE state:
  - Refund event with credit > 0 → CHANGE.
  - Refund event with credit = 0 → no action.
  - Buy event, and refund is not present:
    - If price ≠ 0 and credit ≥ price: latch price into `price_l` and go to VEND.
    - Otherwise pulse `short` and stay in IDLE.
  - Coin event, and no buy/refund event in the same cycle:
    - Value v = VAL_Q, VAL_D or VAL_N, chosen by priority Q > D > N. Lower-priority simultaneous coins are dropped silently.
    - If credit + v ≤ CREDIT_MAX, then credit ← credit + v, computed W+1 bits wide with no wrap.
    - Otherwise pulse `coin_reject` and leave credit unchanged.
  - Coin event in the same cycle as a buy or refund event: pulse `coin_reject`.
- FSM, VEND state (exactly one cycle):
  - `dispense` = 1 during this cycle.
  - credit ← credit − `price_l`; never negative, guaranteed by the entry check.
  - Next state CHANGE.
- FSM, CHANGE state (exactly one cycle):
  - If credit > 0: `change_amt` ← credit, `change_valid` = 1, credit ← 0.
  - If credit = 0: no pulse, and `change_amt` is unchanged.
  - Next state IDLE.
- Any coin event while in VEND or CHANGE: pulse `coin_reject`, credit unaffected. Buy/refund events in VEND or CHANGE are ignored.
- `busy` = (state ≠ IDLE).
- All outputs are registered.
- Latency: event pulse at cycle E → `dispense` at E+1 → `change_valid` at E+2 → `busy` low at E+3.
- A `price` change after the buy event has no effect on the transaction in progress.

Test Plan:
- Glitch rejection, DB_TICKS = 3:
  - Stimulus: `coin_q` high for 1 tick, then low.
  - Required: credit stays 0, no `coin_reject`.
  - Stimulus: `coin_q` held high ≥ 3 ticks.
  - Required: credit = 25, exactly one credit increment even if the switch stays held for 10 ticks.
- Accumulate and saturate:
  - Stimulus: 10 quarters.
  - Required: credit = 250.
  - Stimulus: an 11th quarter.
  - Required: `coin_reject` pulse, credit stays 250.
  - Stimulus: a nickel at credit 250.
  - Required: rejected.
- Vend with change:
  - Stimulus: credit 100, price 75, buy.
  - Required: `dispense` at E+1; `change_valid` at E+2 with `change_amt` = 25; credit = 0; `busy` high for exactly 2 cycles.
- Exact pay and short:
  - Stimulus: credit 50, price 50, buy.
  - Required: `dispense`, no `change_valid`.
  - Stimulus: credit 30, price 50, buy.
  - Required: `short` pulse, credit = 30, FSM stays in IDLE.
  - Stimulus: price 0, buy.
  - Required: `short` pulse.
- Refund and collisions:
  - Stimulus: credit 40, buy and refund in the same cycle.
  - Required: `change_amt` = 40, no `dispense`.
  - Stimulus: coin simultaneous with buy.
  - Required: `coin_reject`.
  - Stimulus: Q and N simultaneous.
  - Required: credit increases by 25 only.
- Reset mid-operation:
  - Stimulus: assert `clr_n` = 0 during the VEND cycle.
  - Required: all outputs 0 immediately, no `change_valid` afterwards.
  - Stimulus: release reset, insert one dime.
  - Required: credit = 10.
